// File: rtl/abr_sipo_pkg.sv
// Shared constants, default rate tables and rate-mode encoding for the
// multi-mode SIPO packer.
package abr_sipo_pkg;

  localparam int SIPO_NUM_MODES    = 5;
  localparam int SIPO_BUFFER_W_DEF = 1408;
  localparam int SIPO_PTR_W_DEF    = $clog2(SIPO_BUFFER_W_DEF + 1);

  localparam int SIPO_INPUT_RATES_DEF  [SIPO_NUM_MODES] = '{64, 64, 64, 64, 64};
  localparam int SIPO_OUTPUT_RATES_DEF [SIPO_NUM_MODES] = '{1088, 1344, 1088, 832, 576};

  typedef enum logic [2:0] {
    SHA3_256 = 3'd0,
    SHAKE128 = 3'd1,
    SHAKE256 = 3'd2,
    SHA3_384 = 3'd3,
    SHA3_512 = 3'd4
  } sipo_mode_e;

  // Smallest storage that can hold a full output block plus one more input word.
  function automatic int sipo_min_buffer_w();
    int max_in;
    int max_out;
    max_in  = 0;
    max_out = 0;
    for (int i = 0; i < SIPO_NUM_MODES; i++) begin
      if (SIPO_INPUT_RATES_DEF[i] > max_in) begin
        max_in = SIPO_INPUT_RATES_DEF[i];
      end else begin
        max_in = max_in;
      end
      if (SIPO_OUTPUT_RATES_DEF[i] > max_out) begin
        max_out = SIPO_OUTPUT_RATES_DEF[i];
      end else begin
        max_out = max_out;
      end
    end
    return max_in + max_out;
  endfunction

endpackage

// File: rtl/abr_sipo_mask_gen.sv
// Ones-below-N mask: bits [N-1:0] set, everything above cleared; N >= W
// saturates to all ones.
module abr_sipo_mask_gen
  import abr_sipo_pkg::*;
#(
  parameter int W   = 64,
  parameter int N_W = SIPO_PTR_W_DEF
) (
  input  logic [N_W-1:0] n_i,
  output logic [W-1:0]   mask_o
);

  assign mask_o = ~({W{1'b1}} << n_i);

endmodule

// File: rtl/abr_sipo_multi.sv
// Multi-mode serial-in/parallel-out packer with valid/hold flow control.
// Optional partial-block flush is enabled by defining ABR_SIPO_FLUSH_EN.
module abr_sipo_multi
  import abr_sipo_pkg::*;
#(
  parameter int NUM_MODES            = SIPO_NUM_MODES,
  parameter int SIPO_BUFFER_W        = SIPO_BUFFER_W_DEF,
  parameter int SIPO_PTR_W           = $clog2(SIPO_BUFFER_W + 1),
  parameter int SIPO_ACT_INPUT_RATE  = 64,
  parameter int SIPO_ACT_OUTPUT_RATE = 1344,
  parameter int INPUT_RATES  [NUM_MODES] = SIPO_INPUT_RATES_DEF,
  parameter int OUTPUT_RATES [NUM_MODES] = SIPO_OUTPUT_RATES_DEF,
  parameter int MODE_W               = $clog2(NUM_MODES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            zeroize,
  input  logic [MODE_W-1:0]               mode,
  input  logic                            valid_i,
  output logic                            hold_o,
  input  logic [SIPO_ACT_INPUT_RATE-1:0]  data_i,
  output logic                            valid_o,
  input  logic                            hold_i,
  output logic [SIPO_ACT_OUTPUT_RATE-1:0] data_o
`ifdef ABR_SIPO_FLUSH_EN
  ,
  input  logic                            flush_i
`endif
);

  localparam logic [SIPO_PTR_W-1:0] BUF_W_P   = SIPO_PTR_W'(SIPO_BUFFER_W);
  localparam logic [MODE_W-1:0]     LAST_MODE = MODE_W'(NUM_MODES - 1);

  logic [SIPO_BUFFER_W-1:0]        buffer_q, buffer_d;
  logic [SIPO_PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic                            flush_pend_s;
  logic [SIPO_PTR_W-1:0]           in_rate_tab  [NUM_MODES];
  logic [SIPO_PTR_W-1:0]           out_rate_tab [NUM_MODES];
  logic [SIPO_PTR_W-1:0]           in_rate_s, out_rate_s, rd_amt_s;
  logic [SIPO_ACT_INPUT_RATE-1:0]  in_mask_s;
  logic [SIPO_ACT_OUTPUT_RATE-1:0] out_mask_s;
  logic [SIPO_BUFFER_W-1:0]        wdata_s;
  logic                            wr_s, rd_s;

  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_rate
    assign in_rate_tab[gi]  = SIPO_PTR_W'(INPUT_RATES[gi]);
    assign out_rate_tab[gi] = SIPO_PTR_W'(OUTPUT_RATES[gi]);
  end

  // Out-of-range mode codes fall back to mode 0 so the datapath never stalls.
  assign in_rate_s  = (mode <= LAST_MODE) ? in_rate_tab[mode]  : in_rate_tab[0];
  assign out_rate_s = (mode <= LAST_MODE) ? out_rate_tab[mode] : out_rate_tab[0];
  assign rd_amt_s   = (out_rate_s < wr_ptr_q) ? out_rate_s : wr_ptr_q;

  abr_sipo_mask_gen #(.W(SIPO_ACT_INPUT_RATE), .N_W(SIPO_PTR_W)) u_in_mask (
    .n_i    (in_rate_s),
    .mask_o (in_mask_s)
  );

  abr_sipo_mask_gen #(.W(SIPO_ACT_OUTPUT_RATE), .N_W(SIPO_PTR_W)) u_out_mask (
    .n_i    (rd_amt_s),
    .mask_o (out_mask_s)
  );

  assign wdata_s = {{(SIPO_BUFFER_W - SIPO_ACT_INPUT_RATE){1'b0}}, data_i & in_mask_s};

  assign hold_o  = (wr_ptr_q > (BUF_W_P - in_rate_s)) | flush_pend_s;
  assign valid_o = (wr_ptr_q >= out_rate_s) | (flush_pend_s & (wr_ptr_q != '0));
  assign wr_s    = valid_i & ~hold_o;
  assign rd_s    = valid_o & ~hold_i;
  assign data_o  = buffer_q[SIPO_ACT_OUTPUT_RATE-1:0] & out_mask_s;

  // Buffer/pointer next state; stale bits above wr_ptr stay zero so OR-merge is safe.
  always_comb begin
    buffer_d = buffer_q;
    wr_ptr_d = wr_ptr_q;
    case ({wr_s, rd_s})
      2'b00: begin
        buffer_d = buffer_q;
        wr_ptr_d = wr_ptr_q;
      end
      2'b10: begin
        buffer_d = buffer_q | (wdata_s << wr_ptr_q);
        wr_ptr_d = wr_ptr_q + in_rate_s;
      end
      2'b01: begin
        buffer_d = buffer_q >> out_rate_s;
        wr_ptr_d = wr_ptr_q - rd_amt_s;
      end
      2'b11: begin
        buffer_d = (buffer_q >> out_rate_s) | (wdata_s << (wr_ptr_q - out_rate_s));
        wr_ptr_d = wr_ptr_q + in_rate_s - out_rate_s;
      end
      default: begin
        buffer_d = buffer_q;
        wr_ptr_d = wr_ptr_q;
      end
    endcase
  end

  // Main state register with synchronous reset/zeroize.
  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      buffer_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      buffer_q <= buffer_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

`ifdef ABR_SIPO_FLUSH_EN
  logic flush_pend_q, flush_pend_d;

  // Pending flush drops on the edge where the buffer becomes empty.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (flush_pend_q) begin
      flush_pend_d = (wr_ptr_d != '0);
    end else begin
      flush_pend_d = flush_i;
    end
  end

  // Flush-pending register.
  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end

  assign flush_pend_s = flush_pend_q;
`else
  assign flush_pend_s = 1'b0;
`endif

endmodule

// File: doc/abr_sipo_multi.md
Name: abr_sipo_multi

Overview:
- Multi-mode serial-in/parallel-out packer: accepts narrow words (e.g. 64-bit lanes) and emits wide blocks (e.g. a 1088/1344-bit sponge rate block) once enough bits are collected.
- Per-mode input and output rates are selected at runtime by `mode`.
- Sits between a narrow producer (message/seed loader) and a Keccak absorb port.
- Uses the same valid/hold flow control as the rest of the abr_libs buffers.

Parameters:
- NUM_MODES, 5, number of rate modes.
- SIPO_BUFFER_W, 1408, storage width. Must be ≥ max(OUTPUT_RATES) + max(INPUT_RATES).
- SIPO_PTR_W, $clog2(SIPO_BUFFER_W+1), write pointer width; can represent a completely full buffer.
- SIPO_ACT_INPUT_RATE, 64, physical data_i width; ≥ every INPUT_RATES entry.
- SIPO_ACT_OUTPUT_RATE, 1344, physical data_o width; ≥ every OUTPUT_RATES entry.
- INPUT_RATES[NUM_MODES], '{64,64,64,64,64}, valid input bits per accepted word, per mode.
- OUTPUT_RATES[NUM_MODES], '{1088,1344,1088,832,576}, bits per emitted block, per mode.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- zeroize, input, 1, synchronous clear of all state; same effect as rst.
- mode, input, $clog2(NUM_MODES), rate select. Changed only while the buffer is empty.
- valid_i, input, 1, input word valid.
- hold_o, output, 1, back-pressure to the producer.
- data_i, input, SIPO_ACT_INPUT_RATE, input word, LSB-first.
- valid_o, output, 1, wide block valid.
- hold_i, input, 1, back-pressure from the consumer.
- data_o, output, SIPO_ACT_OUTPUT_RATE, wide block.
- flush_i, input, 1, present only with ABR_SIPO_FLUSH_EN; emits a partial block.

Behaviour:
- Reset/zeroize (rst wins; both take effect at the next clk edge):
  - buffer = 0, wr_ptr = 0, flush_pend = 0.
  - Outputs after reset: valid_o = 0, hold_o = 0, data_o = 0.
- Rate selection: in_rate = INPUT_RATES[mode] and out_rate = OUTPUT_RATES[mode], both truncated to SIPO_PTR_W.
- Flow control:
  - hold_o = (wr_ptr > SIPO_BUFFER_W − in_rate) | flush_pend.
  - valid_o = (wr_ptr ≥ out_rate) | (flush_pend & wr_ptr ≠ 0).
  - wr = valid_i & ~hold_o; rd = valid_o & ~hold_i.
- Output data:
  - data_o = buffer[SIPO_ACT_OUTPUT_RATE−1:0] AND mask.
  - mask has ones in bits [min(out_rate, wr_ptr)−1:0] and zeros elsewhere.
  - Bits above the current rate therefore read as 0 (zero-padded partial blocks).
- Input masking: wdata = zero-extended data_i AND ones[in_rate−1:0]. Bits above in_rate are discarded.
- Update, registered, latency 1; a word accepted at cycle N is visible in wr_ptr at N+1:
  - none: hold state.
  - wr only: buffer |= wdata << wr_ptr; wr_ptr += in_rate.
  - rd only: buffer >>= out_rate; wr_ptr −= min(out_rate, wr_ptr).
  - rd & wr in the same cycle: buffer = (buffer >> out_rate) | (wdata << (wr_ptr − out_rate)); wr_ptr += in_rate − out_rate. Legal only when wr_ptr ≥ out_rate.
    - If rd occurs during a flush, hold_o is already 1, so wr is 0.
- Throughput: wr and rd together sustain one word per cycle; a block is presented the cycle after the last contributing word lands.
- Bits above wr_ptr are always 0. OR-merge relies on this invariant.
- Full: when wr_ptr > SIPO_BUFFER_W − in_rate, hold_o stays asserted until rd; no word is dropped or overwritten.
- Empty: valid_o = 0.
- A producer holding valid_i while hold_o = 1 must keep data_i stable.
- mode change with wr_ptr ≠ 0 is illegal; result is undefined but must not lock up, and zeroize recovers.

Optional Feature:
- Macro: ABR_SIPO_FLUSH_EN.
- Defined:
  - flush_i sets flush_pend.
  - flush_pend clears in the cycle wr_ptr becomes 0; if wr_ptr is already 0, it clears next cycle with no output.
  - While flush_pend is set, every remaining bit is drained, including a final partial block zero-padded to out_rate.
- Undefined: flush_i port absent, flush_pend tied 0, partial data waits for more input.

Decomposition:
- Package abr_sipo_pkg holds:
  - the default rate arrays;
  - the mode enum (SHA3_256, SHAKE128, SHAKE256, …);
  - a function computing the min legal SIPO_BUFFER_W for elaboration-time asserts.
- Sub-module abr_sipo_mask_gen (ones-below-N mask, used for input and output masking).

Test Plan:
- Mode 0, 17 back-to-back 64-bit words 0x0..0x10, hold_i = 0 → valid_o one cycle after the 17th accept; data_o[1087:0] = concatenation (word0 at LSB); data_o[1343:1088] = 0; wr_ptr returns to 0.
- Mode 1, 42 words streamed with hold_i = 0 → two 1344-bit blocks, each exactly 21 words; hold_o never asserts.
- Mode 0, hold_i = 1 throughout, valid_i = 1 → hold_o rises after wr_ptr = 1344 (21 accepts; wr_ptr > 1344 is the threshold); dropping hold_i yields block 1, then block 2 once the remaining words complete it; no word lost.
- Simultaneous rd & wr at wr_ptr = 1088 (mode 0) → wr_ptr next = 64; buffer[63:0] = new word.
- ABR_SIPO_FLUSH_EN, mode 3, 5 words, then flush_i → valid_o with data_o[319:0] = words, data_o[831:320] = 0; hold_o high until drained. flush_i with empty buffer → no valid_o.
- Reset and zeroize asserted mid-fill (wr_ptr = 640) → next cycle wr_ptr = 0, valid_o = 0, data_o = 0, buffer = 0.
